rv_fp_sqrt_seq: RTL and testbench

Multi-lane, iterative IEEE-754 single-precision square-root unit for the FPU execute stage. It is the sequential successor to the lockstep lane-array sqrt wrapper. All lanes share one radix-2 digit-recurrence FSM and run in lockstep, with these additions:
- honours `frm` rounding;
- handles special operands;
- raises real NV/NX flags;
- supports a per-lane active mask;
- tracks the tag with the operation.

---
 rtl/rv_fp_sqrt_seq.sv | 215 +++++++++++++++++++++
 tb/tb_rv_fp_sqrt_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rv_fp_sqrt_seq.sv
// rv_fp_sqrt_seq: multi-lane iterative IEEE-754 single-precision square root.
// All lanes share one FSM (IDLE -> CALC -> ROUND -> DONE) and run a radix-2
// restoring digit recurrence in lockstep, one root bit per cycle for 26 cycles.
// Ports:
//   clk, reset (sync, active low)
//   valid_in/ready_in/tag_in/frm/lane_mask/dataa : operation request
//   valid_out/ready_out/result/tag_out            : result handshake
//   has_fflags, fflags_{NV,DZ,OF,UF,NX}           : per-lane exception flags

// Per-lane datapath: operand capture, root recurrence, rounding and packing.
module rv_fp_sqrt_lane #(
  parameter int FRMW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            fin,
  input  logic [31:0]     a,
  input  logic [FRMW-1:0] rm,
  input  logic            act,
  output logic [31:0]     res,
  output logic            nv,
  output logic            nx
);
  logic [31:0] op;
  logic        act_q;
  logic [51:0] rad;
  logic [27:0] rem;
  logic [25:0] q;

  logic [29:0] rem_sh, trial;
  logic        ge;
  logic [27:0] rem_nx;
  logic [24:0] x25;

  // Odd unbiased exponent <=> even biased exponent: pre-shift the mantissa.
  assign x25    = a[23] ? {1'b0, 1'b1, a[22:0]} : {1'b1, a[22:0], 1'b0};
  assign rem_sh = {rem, rad[51:50]};
  assign trial  = {2'b00, q, 2'b01};
  assign ge     = rem_sh >= trial;
  assign rem_nx = ge ? 28'(rem_sh - trial) : rem_sh[27:0];

  logic [7:0]  e_b;
  logic [8:0]  e_sum;
  logic [7:0]  e_r;
  logic        g, rb, st, up;
  logic [30:0] mag;
  logic [31:0] res_n;
  logic        nv_n, nx_n;

  assign e_b   = op[30:23];
  // (e/2)+127 with e already forced even: (E + 126 + E[0]) >> 1.
  assign e_sum = {1'b0, e_b} + 9'd126 + {8'd0, e_b[0]};
  assign e_r   = e_sum[8:1];
  assign g     = q[1];
  assign rb    = q[0];
  assign st    = |rem;

  always_comb begin
    up = 1'b0;
    case (rm)
      FRMW'(0): up = g & (rb | st | q[2]);
      FRMW'(3): up = g | rb | st;
      FRMW'(4): up = g;
      default:  up = 1'b0;
    endcase
  end

  // Mantissa carry-out ripples into the exponent field naturally.
  assign mag = {e_r, q[24:2]} + 31'(up);

  always_comb begin
    res_n = 32'd0;
    nv_n  = 1'b0;
    nx_n  = 1'b0;
    if (!act_q) begin
      res_n = 32'd0;
    end else if (e_b == 8'hFF && op[22:0] != 23'd0) begin
      res_n = 32'h7FC00000;
      nv_n  = ~op[22];
    end else if (e_b == 8'd0) begin
      res_n = {op[31], 31'd0};            // zero or flushed subnormal
    end else if (op[31]) begin
      res_n = 32'h7FC00000;
      nv_n  = 1'b1;
    end else if (e_b == 8'hFF) begin
      res_n = 32'h7F800000;
    end else begin
      res_n = {1'b0, mag};
      nx_n  = g | rb | st;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op <= '0; act_q <= 1'b0; rad <= '0; rem <= '0; q <= '0;
      res <= '0; nv <= 1'b0; nx <= 1'b0;
    end else begin
      if (load) begin
        op    <= a;
        act_q <= act;
        rad   <= {x25, 27'd0};
        rem   <= '0;
        q     <= '0;
      end else if (step) begin
        rad <= {rad[49:0], 2'b00};
        rem <= rem_nx;
        q   <= {q[24:0], ge};
      end
      if (fin) begin
        res <= res_n;
        nv  <= nv_n;
        nx  <= nx_n;
      end
    end
  end
endmodule

module rv_fp_sqrt_seq #(
  parameter int TAGW          = 2,
  parameter int LANES         = 2,
  parameter int INST_FRM_BITS = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_in,
  input  logic [TAGW-1:0]          tag_in,
  input  logic [INST_FRM_BITS-1:0] frm,
  input  logic [LANES-1:0]         lane_mask,
  input  logic [LANES*32-1:0]      dataa,
  input  logic                     ready_out,
  output logic                     valid_out,
  output logic [LANES*32-1:0]      result,
  output logic [TAGW-1:0]          tag_out,
  output logic                     has_fflags,
  output logic [LANES-1:0]         fflags_NV,
  output logic [LANES-1:0]         fflags_DZ,
  output logic [LANES-1:0]         fflags_OF,
  output logic [LANES-1:0]         fflags_UF,
  output logic [LANES-1:0]         fflags_NX
);
  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t                   state, state_n;
  logic [4:0]               cnt;
  logic [TAGW-1:0]          tag_q;
  logic [INST_FRM_BITS-1:0] frm_q;
  logic                     accept, calc_en, round_en;

  assign accept   = (state == IDLE) && valid_in;
  assign calc_en  = (state == CALC);
  assign round_en = (state == ROUND);

  assign has_fflags = 1'b1;
  assign fflags_DZ  = '0;
  assign fflags_OF  = '0;
  assign fflags_UF  = '0;

  always_comb begin
    state_n   = state;
    ready_in  = 1'b0;
    valid_out = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) state_n = CALC;
      end
      CALC:  if (cnt == 5'd25) state_n = ROUND;
      ROUND: state_n = DONE;
      DONE: begin
        valid_out = 1'b1;
        if (ready_out) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      tag_q   <= '0;
      frm_q   <= '0;
      tag_out <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        tag_q <= tag_in;
        frm_q <= frm;
        cnt   <= '0;
      end else if (calc_en) begin
        cnt <= cnt + 5'd1;
      end
      if (round_en) tag_out <= tag_q;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rv_fp_sqrt_lane #(.FRMW(INST_FRM_BITS)) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (accept),
      .step (calc_en),
      .fin  (round_en),
      .a    (dataa[32*i +: 32]),
      .rm   (frm_q),
      .act  (lane_mask[i]),
      .res  (result[32*i +: 32]),
      .nv   (fflags_NV[i]),
      .nx   (fflags_NX[i])
    );
  end
endmodule

// File: tb/tb_rv_fp_sqrt_seq.sv
// Self-checking bench for rv_fp_sqrt_seq: directed corner cases plus random
// operands compared against an integer-square-root reference model.
module tb_rv_fp_sqrt_seq;
  localparam int TAGW = 2, LANES = 2, FB = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                valid_in = 1'b0;
  logic                ready_in;
  logic [TAGW-1:0]     tag_in = '0;
  logic [FB-1:0]       frm = '0;
  logic [LANES-1:0]    lane_mask = '0;
  logic [LANES*32-1:0] dataa = '0;
  logic                ready_out = 1'b0;
  logic                valid_out;
  logic [LANES*32-1:0] result;
  logic [TAGW-1:0]     tag_out;
  logic                has_fflags;
  logic [LANES-1:0]    fflags_NV, fflags_DZ, fflags_OF, fflags_UF, fflags_NX;

  int tests = 0;
  int fails = 0;

  rv_fp_sqrt_seq #(.TAGW(TAGW), .LANES(LANES), .INST_FRM_BITS(FB)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .tag_in(tag_in), .frm(frm), .lane_mask(lane_mask), .dataa(dataa),
    .ready_out(ready_out), .valid_out(valid_out), .result(result),
    .tag_out(tag_out), .has_fflags(has_fflags), .fflags_NV(fflags_NV),
    .fflags_DZ(fflags_DZ), .fflags_OF(fflags_OF), .fflags_UF(fflags_UF),
    .fflags_NX(fflags_NX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // Reference: exact integer square root of the scaled significand.
  task automatic model(input logic [31:0] a, input int rm, input bit act,
                       output logic [31:0] r, output bit nv, output bit nx);
    int e;
    longint unsigned x, rad, q, rem;
    bit g, rr, st, lsb, up;
    logic [30:0] mag;
    r = 32'd0; nv = 1'b0; nx = 1'b0;
    if (!act) r = 32'd0;
    else if (a[30:23] == 8'hFF && a[22:0] != 0) begin r = 32'h7FC00000; nv = !a[22]; end
    else if (a[30:23] == 8'd0) r = {a[31], 31'd0};
    else if (a[31]) begin r = 32'h7FC00000; nv = 1'b1; end
    else if (a[30:23] == 8'hFF) r = 32'h7F800000;
    else begin
      e = int'(a[30:23]) - 127;
      x = 64'h800000 + 64'(a[22:0]);
      if (e % 2 != 0) begin x = x * 2; e = e - 1; end
      rad = x << 27;
      q = longint'($sqrt(real'(rad)));
      while (q * q > rad) q = q - 1;
      while ((q + 1) * (q + 1) <= rad) q = q + 1;
      rem = rad - q * q;
      g = q[1]; rr = q[0]; st = (rem != 0); lsb = q[2];
      case (rm)
        0: up = g && (rr || st || lsb);
        3: up = g || rr || st;
        4: up = g;
        default: up = 1'b0;
      endcase
      mag = {8'(e / 2 + 127), q[24:2]};
      mag = mag + 31'(up);
      r = {1'b0, mag};
      nx = g || rr || st;
    end
  endtask

  task automatic run_op(input logic [1:0] tg, input int rm, input logic [1:0] msk,
                        input logic [31:0] a0, input logic [31:0] a1, input int hold);
    logic [31:0] er;
    bit env, enx;
    int lat;
    logic [63:0] snap;
    logic [31:0] ops [2];
    ops[0] = a0; ops[1] = a1;
    @(negedge clk);
    chk("ready_idle", 64'(ready_in), 64'd1);
    valid_in = 1'b1; tag_in = tg; frm = FB'(rm); lane_mask = msk; dataa = {a1, a0};
    @(negedge clk);
    valid_in = 1'b0; dataa = {$urandom, $urandom}; frm = FB'($urandom_range(0, 4));
    tag_in = ~tg; lane_mask = ~msk;
    lat = 0;
    while (!valid_out && lat < 60) begin @(negedge clk); lat++; end
    chk("latency", 64'(lat), 64'd27);
    for (int i = 0; i < LANES; i++) begin
      model(ops[i], rm, msk[i], er, env, enx);
      chk($sformatf("result_l%0d a=%h rm=%0d", i, ops[i], rm), 64'(result[32*i +: 32]), 64'(er));
      chk($sformatf("nv_l%0d", i), 64'(fflags_NV[i]), 64'(env));
      chk($sformatf("nx_l%0d", i), 64'(fflags_NX[i]), 64'(enx));
    end
    chk("tag_out", 64'(tag_out), 64'(tg));
    chk("dz_of_uf", 64'({fflags_DZ, fflags_OF, fflags_UF}), 64'd0);
    snap = 64'(result);
    for (int c = 0; c < hold; c++) begin
      valid_in = 1'b1;           // must be ignored while busy
      @(negedge clk);
      chk("bp_result", 64'(result), snap);
      chk("bp_tag", 64'(tag_out), 64'(tg));
      chk("bp_valid", 64'(valid_out), 64'd1);
      chk("bp_ready_in", 64'(ready_in), 64'd0);
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    chk("ready_after_pop", 64'(ready_in), 64'd1);
    chk("valid_after_pop", 64'(valid_out), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit seen;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_flags", 64'({fflags_NV, fflags_NX, fflags_DZ, fflags_OF, fflags_UF}), 64'd0);
    chk("has_fflags", 64'(has_fflags), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready_in", 64'(ready_in), 64'd1);

    // Exact roots
    run_op(2'd1, 0, 2'b11, 32'h40800000, 32'h3F800000, 0);
    chk("exact_lane0", 64'(result[31:0]), 64'h40000000);
    chk("exact_nx", 64'(fflags_NX), 64'd0);
    // sqrt(2) under several rounding modes
    run_op(2'd0, 0, 2'b11, 32'h40000000, 32'h40000000, 0);
    chk("sqrt2_rne", 64'(result[31:0]), 64'h3FB504F3);
    run_op(2'd2, 3, 2'b11, 32'h40000000, 32'h40000000, 0);
    chk("sqrt2_rup", 64'(result[31:0]), 64'h3FB504F4);
    run_op(2'd3, 1, 2'b11, 32'h40000000, 32'h40000000, 0);
    chk("sqrt2_rtz", 64'(result[31:0]), 64'h3FB504F3);
    // Specials
    run_op(2'd0, 0, 2'b11, 32'hBF800000, 32'h7F800001, 0);
    chk("neg_one", 64'(result[31:0]), 64'h7FC00000);
    chk("snan_nv", 64'(fflags_NV), 64'd3);
    run_op(2'd1, 0, 2'b11, 32'h7FC00000, 32'h80000000, 0);
    chk("qnan_nv", 64'(fflags_NV[0]), 64'd0);
    chk("neg_zero", 64'(result[63:32]), 64'h80000000);
    run_op(2'd2, 0, 2'b11, 32'h7F800000, 32'h00000001, 0);
    chk("pinf", 64'(result[31:0]), 64'h7F800000);
    chk("subnorm", 64'(result[63:32]), 64'h00000000);
    run_op(2'd3, 2, 2'b11, 32'hFF800000, 32'h00000000, 0);
    // Mask and tag
    run_op(2'd3, 0, 2'b10, 32'hBF800000, 32'h41100000, 0);
    chk("mask_l0", 64'(result[31:0]), 64'd0);
    chk("mask_l1", 64'(result[63:32]), 64'h40400000);
    chk("mask_tag", 64'(tag_out), 64'd3);
    // Back-pressure, then a second op with a different tag
    run_op(2'd2, 0, 2'b11, 32'h40400000, 32'h3F000000, 5);
    run_op(2'd1, 4, 2'b01, 32'h42F60000, 32'h3E800000, 0);

    // Reset during CALC
    @(negedge clk);
    valid_in = 1'b1; tag_in = 2'd2; frm = 3'd0; lane_mask = 2'b11;
    dataa = {32'h40800000, 32'h40800000};
    @(negedge clk);
    valid_in = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_tag", 64'(tag_out), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(ready_in), 64'd1);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (valid_out) seen = 1'b1; end
    chk("midrst_no_emit", 64'(seen), 64'd0);

    // Random operands
    for (int n = 0; n < 30; n++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 3) != 0) ra[31] = 1'b0;
      if ($urandom_range(0, 3) != 0) rb[31] = 1'b0;
      run_op(2'($urandom), $urandom_range(0, 4), 2'($urandom_range(0, 3)), ra, rb,
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
